dca_matrix_store_row_writer: RTL and testbench
==============================================

Name: dca_matrix_store_row_writer

Overview:
Downstream consumer of a matrix unit's store-row stream. Pulls up to MATRIX_SIZE_PARA tensor rows from the store interface and writes each row to memory. Each row goes to a base address plus a per-command row stride. It sits between the matrix register store path and the LSU/memory write port, and signals completion of each store command with a one-cycle pulse.

Parameters:
MATRIX_SIZE_PARA, 8, rows per matrix and scalars per row
BW_TENSOR_SCALAR, 32, bits per scalar
BW_ADDR, 32, memory address width
BW_ROW, MATRIX_SIZE_PARA*BW_TENSOR_SCALAR, row width (derived; do not override)
BW_NUM_ROW, clog2(MATRIX_SIZE_PARA)+1, row-count width (derived)

Ports:
clk  in  1  clock
rstnn  in  1  asynchronous active-low reset
clear  in  1  synchronous flush, active high
enable  in  1  global advance; 0 freezes the block
busy  out  1  command in progress or buffer non-empty
cmd_valid  in  1  store command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_addr  in  BW_ADDR  address of row 0
cmd_stride  in  BW_ADDR  byte distance between consecutive rows
cmd_num_row  in  BW_NUM_ROW  rows to store
cmd_done  out  1  one-cycle pulse, command complete
row_rready  in  1  upstream has a row available
row_rvalid  out  1  pull request; transfer when row_rready&row_rvalid
row_rlast  out  1  high with row_rvalid on the final pull of a command
row_rdata  in  BW_ROW  row data, sampled on transfer
mem_wreq  out  1  write request
mem_wgrant  in  1  write accepted when mem_wreq&mem_wgrant
mem_waddr  out  BW_ADDR  write address
mem_wdata  out  BW_ROW  write data
mem_wlast  out  1  high with the final row write of a command

Behaviour:
- Reset (rstnn=0, async): state IDLE; counters and buffer cleared. All outputs 0 except cmd_ready=1.
- FSM has two states:
  - IDLE: cmd_ready=1 when enable=1. On accept, latch addr/stride/num_row, saturating num_row at MATRIX_SIZE_PARA.
    - num_row=0: stay IDLE and pulse cmd_done on the next cycle; no row or memory transfer occurs.
    - num_row>0: go to RUN.
  - RUN: cmd_ready=0. Return to IDLE on the cycle after the final memory write transfer. cmd_done pulses in that same cycle.
- Pull counter pcnt (0..num_row), write counter wcnt (0..num_row), 2-entry row FIFO holding {data, addr, last}.
- row_rvalid = RUN & enable & pcnt<num_row & fifo_count<2.
  - fifo_count<2 uses the current count only; a same-cycle pop does not free a slot.
- row_rlast = row_rvalid & (pcnt==num_row-1).
- On a pull transfer, push {row_rdata, waddr, rlast} and increment pcnt.
  - waddr register starts at cmd_addr and adds cmd_stride after each pull, modulo 2^BW_ADDR (wrap, no error).
- mem_wreq = enable & fifo non-empty. mem_waddr/mem_wdata/mem_wlast come from the FIFO head.
  - mem_waddr/mem_wdata/mem_wlast are stable while mem_wreq=1 and mem_wgrant=0.
  - On grant, pop the FIFO and increment wcnt.
- Latency: row pulled at cycle t gives mem_wreq at t+1 at the earliest. Sustained throughput is 1 row/cycle with mem_wgrant held high.
- Simultaneous push and pop: allowed; fifo_count is unchanged.
- enable=0: row_rvalid, mem_wreq and cmd_ready are forced 0. All state holds, and cmd_done cannot pulse.
- clear=1: on the next edge go to IDLE, flush the FIFO and zero the counters. A pending cmd_done is cancelled and no cmd_done is issued for the aborted command. clear has priority over all same-cycle events.
- busy = (state==RUN) | fifo non-empty.
- Row data and addresses are never modified; no arithmetic is applied to data.

Test Plan:
- Basic: cmd addr=0x1000, stride=0x20, num_row=4, row_rready=1, mem_wgrant=1, rows R0..R3 → writes to 0x1000, 0x1020, 0x1040, 0x1060 with data R0..R3. row_rlast and mem_wlast are high only on the 4th transfer; cmd_done pulses 1 cycle after the last grant; busy then drops.
- Backpressure: num_row=8, mem_wgrant=0 for 6 cycles → exactly 2 pulls, then row_rvalid=0; mem_waddr/mem_wdata stay stable. After the grant returns, all 8 rows complete in order.
- Zero/saturate: num_row=0 → cmd_done pulse 1 cycle after accept, with no row_rvalid or mem_wreq. num_row=15 with MATRIX_SIZE_PARA=8 → exactly 8 rows are written.
- Wrap: addr=0xFFFFFFF0, stride=0x10, num_row=2 → writes to 0xFFFFFFF0, then 0x00000000.
- Clear mid-operation: clear after 3 of 8 writes → next cycle IDLE, cmd_ready=1, busy=0, no cmd_done. A following 1-row command runs normally.
- Enable freeze: enable=0 for 4 cycles during RUN → no handshakes occur and counters hold. After enable returns, the remaining rows finish with the correct addresses.

Source files
------------

// File: rtl/dca_matrix_store_row_writer.sv
// Pulls store rows into a 2-deep buffer and writes each one to addr + k*stride; mem_wreq at the earliest one cycle after a pull.
// Full rate with mem_wgrant held high; a withheld grant fills the buffer, then stalls row_rvalid.
module dca_matrix_store_row_writer #(
  parameter int MATRIX_SIZE_PARA = 8,
  parameter int BW_TENSOR_SCALAR = 32,
  parameter int BW_ADDR          = 32,
  parameter int BW_ROW           = MATRIX_SIZE_PARA*BW_TENSOR_SCALAR,
  parameter int BW_NUM_ROW       = $clog2(MATRIX_SIZE_PARA)+1
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  clear,
  input  logic                  enable,
  output logic                  busy,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [BW_ADDR-1:0]    cmd_addr,
  input  logic [BW_ADDR-1:0]    cmd_stride,
  input  logic [BW_NUM_ROW-1:0] cmd_num_row,
  output logic                  cmd_done,
  input  logic                  row_rready,
  output logic                  row_rvalid,
  output logic                  row_rlast,
  input  logic [BW_ROW-1:0]     row_rdata,
  output logic                  mem_wreq,
  input  logic                  mem_wgrant,
  output logic [BW_ADDR-1:0]    mem_waddr,
  output logic [BW_ROW-1:0]     mem_wdata,
  output logic                  mem_wlast
);

  localparam logic [BW_NUM_ROW-1:0] MAX_ROW = BW_NUM_ROW'(MATRIX_SIZE_PARA);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [BW_ADDR-1:0]    stride_q, waddr_q;
  logic [BW_NUM_ROW-1:0] num_row_q, pcnt_q, wcnt_q, num_sat;
  logic                  done_q;

  logic [BW_ROW-1:0]  fifo_data [2];
  logic [BW_ADDR-1:0] fifo_addr [2];
  logic [1:0]         fifo_last;
  logic               rd_ptr, wr_ptr;
  logic [1:0]         fifo_cnt;

  logic accept, push, pop, last_wr, fifo_nempty;

  assign num_sat     = (cmd_num_row > MAX_ROW) ? MAX_ROW : cmd_num_row;
  assign fifo_nempty = (fifo_cnt != 2'd0);

  assign cmd_ready  = enable & (state_q == IDLE);
  assign accept     = cmd_valid & cmd_ready;
  // Only the registered count gates the pull; a same-cycle pop never frees a slot early.
  assign row_rvalid = enable & (state_q == RUN) & (pcnt_q < num_row_q) & (fifo_cnt < 2'd2);
  assign row_rlast  = row_rvalid & (pcnt_q == num_row_q - 1'b1);
  assign push       = row_rvalid & row_rready;

  assign mem_wreq  = enable & fifo_nempty;
  assign mem_waddr = fifo_addr[rd_ptr];
  assign mem_wdata = fifo_data[rd_ptr];
  assign mem_wlast = mem_wreq & fifo_last[rd_ptr];
  assign pop       = mem_wreq & mem_wgrant;
  assign last_wr   = pop & (state_q == RUN) & (wcnt_q == num_row_q - 1'b1);

  assign cmd_done = done_q & enable;
  assign busy     = (state_q == RUN) | fifo_nempty;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept && num_sat != '0) state_d = RUN;
        RUN:     if (last_wr) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      stride_q  <= '0;
      waddr_q   <= '0;
      num_row_q <= '0;
      pcnt_q    <= '0;
      wcnt_q    <= '0;
      done_q    <= 1'b0;
      fifo_data <= '{default: '0};
      fifo_addr <= '{default: '0};
      fifo_last <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      fifo_cnt  <= '0;
    end else if (clear) begin
      pcnt_q   <= '0;
      wcnt_q   <= '0;
      done_q   <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      // done_q holds across enable=0 so a pending pulse is delivered once unfrozen.
      if (enable) done_q <= (accept && num_sat == '0) || last_wr;
      if (accept) begin
        stride_q  <= cmd_stride;
        waddr_q   <= cmd_addr;
        num_row_q <= num_sat;
        pcnt_q    <= '0;
        wcnt_q    <= '0;
      end
      if (push) begin
        fifo_data[wr_ptr] <= row_rdata;
        fifo_addr[wr_ptr] <= waddr_q;
        fifo_last[wr_ptr] <= row_rlast;
        wr_ptr            <= ~wr_ptr;
        pcnt_q            <= pcnt_q + 1'b1;
        waddr_q           <= waddr_q + stride_q;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        wcnt_q <= wcnt_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dca_matrix_store_row_writer.sv
// Directed bench for the store-row writer: cycle table for a basic command, hand sequences for corner cases.
module tb_dca_matrix_store_row_writer;

  logic         clk = 1'b0;
  logic         rstnn, clear, enable, busy;
  logic         cmd_valid, cmd_ready, cmd_done;
  logic [31:0]  cmd_addr, cmd_stride;
  logic [3:0]   cmd_num_row;
  logic         row_rready, row_rvalid, row_rlast;
  logic [255:0] row_rdata;
  logic         mem_wreq, mem_wgrant, mem_wlast;
  logic [31:0]  mem_waddr;
  logic [255:0] mem_wdata;

  always #5 clk = ~clk;

  dca_matrix_store_row_writer dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_stride(cmd_stride), .cmd_num_row(cmd_num_row), .cmd_done(cmd_done),
    .row_rready(row_rready), .row_rvalid(row_rvalid), .row_rlast(row_rlast),
    .row_rdata(row_rdata), .mem_wreq(mem_wreq), .mem_wgrant(mem_wgrant),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast)
  );

  int nvec = 0, nerr = 0;
  int pulls, wr_idx, done_cnt = 0, cyc_n = 0, last_wr_cyc = 0;
  logic [31:0] exp_base, exp_stride, last_waddr;
  int exp_n;

  typedef struct {
    logic vld; logic [31:0] addr; logic [31:0] stride; logic [3:0] num; int rk; logic grant;
    logic e_rdy; logic e_rvalid; logic e_rlast; logic e_wreq; logic [31:0] e_waddr; int e_wk;
    logic e_wlast; logic e_done; logic e_busy;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [255:0] rowdat(input int k);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'hD000_0000 + 32'(k*16 + i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic observe();
    logic [31:0] ea;
    cyc_n++;
    if (cmd_done) begin
      done_cnt++;
      chk("busy_at_done", busy, 0);
      chk("done_all_rows", wr_idx, exp_n);
      if (exp_n > 0) chk("done_timing", cyc_n, last_wr_cyc + 1);
    end
    if (row_rvalid) chk("row_rlast", row_rlast, pulls == exp_n - 1);
    if (row_rvalid && row_rready) pulls++;
    if (mem_wreq) begin
      ea = exp_base + 32'(wr_idx) * exp_stride;
      chk("mem_waddr", mem_waddr, ea);
      chk("mem_wdata", mem_wdata, rowdat(wr_idx));
      chk("mem_wlast", mem_wlast, wr_idx == exp_n - 1);
      if (mem_wgrant) begin
        wr_idx++;
        last_wr_cyc = cyc_n;
        last_waddr  = mem_waddr;
      end
    end
  endtask

  task automatic half_obs();
    @(negedge clk);
    observe();
  endtask

  task automatic half_drv();
    @(posedge clk);
    #1;
    row_rdata = rowdat(pulls);
  endtask

  task automatic cyc();
    half_obs();
    half_drv();
  endtask

  task automatic start_cmd(input logic [31:0] a, input logic [31:0] s, input logic [3:0] n);
    cmd_valid = 1'b1; cmd_addr = a; cmd_stride = s; cmd_num_row = n;
    exp_base = a; exp_stride = s; exp_n = (n > 8) ? 8 : int'(n);
    pulls = 0; wr_idx = 0; row_rdata = rowdat(0);
    @(negedge clk);
    chk("cmd_ready_at_accept", cmd_ready, 1);
    observe();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    row_rdata = rowdat(pulls);
  endtask

  task automatic run_until_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      cyc();
      n++;
    end
    chk("done_seen", done_cnt, d0 + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, w0, d0, n;
    //              vld addr         stride  num  rk gnt  rdy rv rl wq waddr       wk wl dn bz
    tbl[0] = '{1'b1, 32'h1000, 32'h20, 4'd4, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h0,    32'h0,  4'd0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 32'h0,    32'h0,  4'd0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000, 0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 32'h0,    32'h0,  4'd0, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1020, 1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 32'h0,    32'h0,  4'd0, 3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1040, 2, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 32'h0,    32'h0,  4'd0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1060, 3, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 32'h0,    32'h0,  4'd0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 32'h0,    32'h0,  4'd0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    0, 1'b0, 1'b0, 1'b0};

    rstnn = 1'b0; clear = 1'b0; enable = 1'b1; cmd_valid = 1'b0;
    cmd_addr = '0; cmd_stride = '0; cmd_num_row = '0;
    row_rready = 1'b1; row_rdata = rowdat(0); mem_wgrant = 1'b1;
    exp_base = '0; exp_stride = '0; exp_n = 0; pulls = 0; wr_idx = 0; last_waddr = '0;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_row_rvalid", row_rvalid, 0);
    chk("rst_row_rlast", row_rlast, 0);
    chk("rst_mem_wreq", mem_wreq, 0);
    chk("rst_mem_wlast", mem_wlast, 0);
    chk("rst_mem_waddr", mem_waddr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rstnn = 1'b1;

    // Basic 4-row command, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      cmd_valid = tbl[i].vld; cmd_addr = tbl[i].addr; cmd_stride = tbl[i].stride;
      cmd_num_row = tbl[i].num; row_rdata = rowdat(tbl[i].rk); mem_wgrant = tbl[i].grant;
      @(negedge clk);
      chk($sformatf("t%0d_cmd_ready", i), cmd_ready, tbl[i].e_rdy);
      chk($sformatf("t%0d_row_rvalid", i), row_rvalid, tbl[i].e_rvalid);
      chk($sformatf("t%0d_row_rlast", i), row_rlast, tbl[i].e_rlast);
      chk($sformatf("t%0d_mem_wreq", i), mem_wreq, tbl[i].e_wreq);
      chk($sformatf("t%0d_mem_wlast", i), mem_wlast, tbl[i].e_wlast);
      chk($sformatf("t%0d_cmd_done", i), cmd_done, tbl[i].e_done);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_wreq) begin
        chk($sformatf("t%0d_mem_waddr", i), mem_waddr, tbl[i].e_waddr);
        chk($sformatf("t%0d_mem_wdata", i), mem_wdata, rowdat(tbl[i].e_wk));
      end
      @(posedge clk);
      #1;
    end

    // Backpressure: grant withheld, buffer fills after two pulls
    mem_wgrant = 1'b0;
    start_cmd(32'h2000, 32'h40, 4'd8);
    repeat (6) cyc();
    @(negedge clk);
    chk("bp_pulls", pulls, 2);
    chk("bp_rvalid_stalled", row_rvalid, 0);
    chk("bp_head_addr", mem_waddr, 32'h2000);
    chk("bp_head_data", mem_wdata, rowdat(0));
    observe();
    half_drv();
    mem_wgrant = 1'b1;
    run_until_done(40);
    chk("bp_total_writes", wr_idx, 8);
    chk("bp_total_pulls", pulls, 8);

    // Zero rows: done one cycle after accept, no traffic
    start_cmd(32'h3000, 32'h4, 4'd0);
    @(negedge clk);
    chk("zero_done", cmd_done, 1);
    chk("zero_rvalid", row_rvalid, 0);
    chk("zero_wreq", mem_wreq, 0);
    observe();
    half_drv();
    chk("zero_pulls", pulls, 0);

    // Saturation: 15 requested, 8 written
    start_cmd(32'h4000, 32'h100, 4'd15);
    run_until_done(40);
    chk("sat_writes", wr_idx, 8);
    chk("sat_last_addr", last_waddr, 32'h4700);

    // Address wrap
    start_cmd(32'hFFFF_FFF0, 32'h10, 4'd2);
    run_until_done(20);
    chk("wrap_writes", wr_idx, 2);
    chk("wrap_last_addr", last_waddr, 32'h0);

    // Clear after three writes
    start_cmd(32'h5000, 32'h8, 4'd8);
    n = 0;
    while (wr_idx < 3 && n < 50) begin
      cyc();
      n++;
    end
    chk("clr_setup_writes", wr_idx, 3);
    d0 = done_cnt;
    clear = 1'b1; mem_wgrant = 1'b0;
    cyc();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_cmd_ready", cmd_ready, 1);
    chk("clr_busy", busy, 0);
    chk("clr_no_done", cmd_done, 0);
    chk("clr_wreq", mem_wreq, 0);
    observe();
    half_drv();
    repeat (3) cyc();
    chk("clr_done_count", done_cnt, d0);
    mem_wgrant = 1'b1;
    start_cmd(32'h6000, 32'h8, 4'd1);
    run_until_done(10);
    chk("clr_next_writes", wr_idx, 1);
    chk("clr_next_addr", last_waddr, 32'h6000);

    // Enable freeze mid-command
    start_cmd(32'h7000, 32'h4, 4'd6);
    repeat (3) cyc();
    p0 = pulls; w0 = wr_idx;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("frz_rvalid", row_rvalid, 0);
      chk("frz_wreq", mem_wreq, 0);
      chk("frz_cmd_ready", cmd_ready, 0);
      chk("frz_busy", busy, 1);
      observe();
      half_drv();
    end
    chk("frz_pulls_hold", pulls, p0);
    chk("frz_writes_hold", wr_idx, w0);
    enable = 1'b1;
    run_until_done(30);
    chk("frz_writes", wr_idx, 6);
    chk("frz_last_addr", last_waddr, 32'h7014);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
